// File: rtl/bcd_bin_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd_bin_seq_ctrl
// Brief    : Sequential NDIG-digit packed-BCD to binary converter, MS digit
//            first, with valid/ready handshakes on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_bin_seq_ctrl #(
  parameter int NDIG = 4,
  parameter int BW   = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BW-1:0]     binary,
  output logic              err,
  output logic              busy
);

  localparam int             c_cnt_w = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [4*NDIG-1:0]   r_shift;
  logic [BW-1:0]       r_acc;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_err_int;
  logic [BW-1:0]       r_binary;
  logic                r_err;
  logic [3:0]          w_digit;
  logic [BW-1:0]       w_acc_next;
  logic                w_err_next;
  logic                w_last;

  assign w_digit    = r_shift[4*NDIG-1 -: 4];
  assign w_acc_next = (r_acc << 3) + (r_acc << 1) + BW'(w_digit);
  assign w_err_next = r_err_int | (w_digit > 4'd9);
  assign w_last     = (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Handshake outputs decode state only, so no input-to-output comb paths.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = S_CONV;
      end
      S_CONV: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Result registers are loaded only on the final digit so they hold between words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_err_int <= 1'b0;
      r_binary  <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift   <= bcd_in;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_err_int <= 1'b0;
          end
        end
        S_CONV: begin
          r_acc     <= w_acc_next;
          r_shift   <= r_shift << 4;
          r_err_int <= w_err_next;
          r_cnt     <= r_cnt + 1'b1;
          if (w_last) begin
            r_binary <= w_acc_next;
            r_err    <= w_err_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign binary = r_binary;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_bin_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_bin_seq_ctrl
// Brief    : Directed table-driven bench for bcd_bin_seq_ctrl (NDIG=4, BW=14).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_bin_seq_ctrl;

  localparam int NDIG = 4;
  localparam int BW   = 14;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [4*NDIG-1:0] bcd_in;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     binary;
  logic              err;
  logic              busy;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {
    logic [15:0] bcd;
    int          exp_bin;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  bcd_bin_seq_ctrl #(.NDIG(NDIG), .BW(BW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .bcd_in   (bcd_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .binary   (binary),
    .err      (err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One full conversion with out_ready high; garbage on bcd_in after accept.
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    bcd_in    = v.bcd;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk("in_ready_idle", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    bcd_in   = 16'hFFFF;
    chk("busy_conv", int'(busy), 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, NDIG);
    chk("binary", int'(binary), v.exp_bin);
    chk("err", int'(err), int'(v.exp_err));
    chk("in_ready_done", int'(in_ready), 0);
    @(negedge clk);
    chk("out_valid_drop", int'(out_valid), 0);
    chk("in_ready_back", int'(in_ready), 1);
    chk("binary_hold", int'(binary), v.exp_bin);
  endtask

  initial begin
    int lat;
    int n_acc;
    int n_res;
    int acc_cyc[2];
    int res[2];

    vecs[0] = '{16'h0097,    97, 1'b0};
    vecs[1] = '{16'h9999,  9999, 1'b0};
    vecs[2] = '{16'h0000,     0, 1'b0};
    vecs[3] = '{16'h00A5,   105, 1'b1};
    vecs[4] = '{16'h0058,    58, 1'b0};
    vecs[5] = '{16'h1234,  1234, 1'b0};
    vecs[6] = '{16'hF000, 15000, 1'b1};
    vecs[7] = '{16'hFFFF,   281, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    bcd_in    = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_binary", int'(binary), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-pressure in DONE, with ignored in_valid pulses while busy.
    @(negedge clk);
    bcd_in    = 16'h0321;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    bcd_in = 16'h1234;
    lat = 0;
    while (!out_valid && lat < 20) begin
      in_valid = ~in_valid;
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, NDIG);
    for (int i = 0; i < 6; i++) begin
      in_valid = ~in_valid;
      chk("bp_out_valid", int'(out_valid), 1);
      chk("bp_binary", int'(binary), 321);
      chk("bp_err", int'(err), 0);
      chk("bp_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    chk("bp_release_busy", int'(busy), 0);

    // Back-to-back words with in_valid held high.
    n_acc = 0;
    n_res = 0;
    bcd_in   = 16'h0012;
    in_valid = 1'b1;
    for (int i = 0; i < 40 && n_res < 2; i++) begin
      if (out_valid) begin
        res[n_res] = int'(binary);
        n_res++;
      end
      if (in_ready && in_valid && n_acc < 2) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
      end else if (!in_ready) begin
        bcd_in   = 16'h0097;
        in_valid = (n_acc < 2);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_results", n_res, 2);
    if (n_acc == 2) chk("b2b_period", acc_cyc[1] - acc_cyc[0], NDIG + 2);
    if (n_res == 2) begin
      chk("b2b_res0", res[0], 12);
      chk("b2b_res1", res[1], 97);
    end
    repeat (2) @(negedge clk);

    // Reset mid-conversion: previous result must be wiped, nothing presented.
    bcd_in   = 16'h9999;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy_pre", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_binary", int'(binary), 0);
    chk("abort_err", int'(err), 0);
    chk("abort_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 1);
    repeat (NDIG + 2) begin
      chk("abort_no_result", int'(out_valid), 0);
      @(negedge clk);
    end
    run_vec('{16'h0058, 58, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
